axi_read_reorder_buffer: RTL and testbench
==========================================

Name: axi_read_reorder_buffer

Overview:
- AXI-style read reorder buffer between an upstream read master (s_ side) and a downstream read slave (m_ side).
- Generalised successor of the single-outstanding-per-ID buffer. Supports up to DEPTH outstanding reads, with any number sharing one ID, and carries RRESP.
- Returns R beats to the upstream master strictly in AR issue order, whatever order the downstream slave answers in across different IDs.
- Single-beat reads only (no bursts / RLAST).

Parameters:
- DATA_WIDTH, 8, R data width.
- ID_WIDTH, 4, AR/R ID width.
- DEPTH, 8, maximum outstanding reads (slot count). Power of two, minimum 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- s_arid_i  in  ID_WIDTH  upstream AR ID.
- s_arvalid_i  in  1  upstream AR valid.
- s_arready_o  out  1  upstream AR ready.
- s_rdata_o  out  DATA_WIDTH  in-order read data.
- s_rresp_o  out  2  in-order read response.
- s_rid_o  out  ID_WIDTH  in-order read ID.
- s_rvalid_o  out  1  in-order R valid.
- s_rready_i  in  1  upstream R ready.
- m_arid_o  out  ID_WIDTH  downstream AR ID (equals s_arid_i).
- m_arvalid_o  out  1  downstream AR valid.
- m_arready_i  in  1  downstream AR ready.
- m_rdata_i  in  DATA_WIDTH  downstream R data.
- m_rresp_i  in  2  downstream R response.
- m_rid_i  in  ID_WIDTH  downstream R ID.
- m_rvalid_i  in  1  downstream R valid.
- m_rready_o  out  1  downstream R ready.
- occupancy_o  out  $clog2(DEPTH)+1  allocated slot count.
- err_unexpected_o  out  1  sticky flag: R beat with no pending match.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Slot storage: DEPTH slots, each holding alloc, filled, id, data, resp. Circular head and tail pointers plus a count.
- Reset values: every slot's alloc=0 and filled=0; head=tail=0; count=0; s_rvalid_o=0; s_rdata_o=0; s_rresp_o=0; s_rid_o=0; occupancy_o=0; err_unexpected_o=0; m_arvalid_o=0; s_arready_o=0.
- Reset mid-operation discards all pending slots. Late R beats arriving after reset set err_unexpected_o.
- AR path:
  - m_arvalid_o = s_arvalid_i && !full.
  - s_arready_o = m_arready_i && !full.
  - m_arid_o = s_arid_i.
  - full means count==DEPTH.
  - Accepted AR (s_arvalid_i && s_arready_o): slot[tail] gets alloc=1, filled=0, id=s_arid_i; tail advances and wraps modulo DEPTH.
- R accept:
  - m_rready_o is constant 1 when out of reset, 0 during reset.
  - Every pending AR owns a slot, so there is no backpressure.
- R match:
  - On m_rvalid_i && m_rready_o, pick the oldest slot, searching from head in circular order, with alloc=1, filled=0 and id==m_rid_i.
  - Write data and resp into it and set filled=1.
  - Same-ID responses therefore land in issue order.
- No match: drop the beat and set err_unexpected_o=1 until reset.
- Output:
  - s_rvalid_o = slot[head].alloc && slot[head].filled.
  - s_rdata_o, s_rresp_o and s_rid_o come from slot[head].
  - These are driven combinationally from registers only; there is no combinational path from any m_ input.
- Pop: s_rvalid_o && s_rready_i clears slot[head] and advances head with wrap.
- Latency: a beat filling the head slot at edge N appears on s_rvalid_o after edge N. Minimum m_r to s_r latency is 1 cycle.
- Stability: while s_rvalid_o && !s_rready_i, all s_r outputs stay stable.
- Count: +1 on accept, -1 on pop, unchanged on simultaneous accept and pop. occupancy_o = count.
- Simultaneous events:
  - Accept and pop in the same cycle at full: allowed only if the combinational full is evaluated before pop. full=1 still blocks AR that cycle, so there is no same-cycle free-slot reuse.
  - Response matching the head slot in the same cycle as a pop of the head: impossible, since the head is already filled.
  - Response into the slot being allocated this cycle: not matched, because the new alloc is not visible until the next edge.
- Wrap-around: pointers wrap modulo DEPTH. Ordering is preserved across the wrap.

Decomposition:
- Shared package rob_pkg:
  - resp_t, a 2-bit enum: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - Slot struct typedef, parameterised via the module's local typedef of package fields.
- Sub-module rob_oldest_match:
  - Combinational rotate-priority finder.
  - Inputs: head and a DEPTH-bit candidate vector.
  - Outputs: found and index.
- Top module holds slot registers, pointers, count, AR/R handshakes.

Test Plan:
- Basic reorder: AR IDs 1,2,3. R returns ID3 (0x33), ID1 (0x11), ID2 (0x22) → s_r order ID1/0x11, ID2/0x22, ID3/0x33.
- Same-ID multiple outstanding: AR ID5 twice. R ID5 0xA0 then ID5 0xB0 → output 0xA0 then 0xB0. ARs at ID5 then ID6, R ID6 0x66 first → held until ID5 returns.
- Full/backpressure: DEPTH=8. Accept 8 ARs, no R → s_arready_o=0, m_arvalid_o=0, occupancy_o=8. Return and pop one → s_arready_o=1 next cycle.
- Upstream stall: s_rready_i=0 with head filled (data 0x5A, resp SLVERR) for 5 cycles → s_rvalid_o=1 and 0x5A/2 stable. Raise ready → pop, occupancy decrements.
- Wrap and error: 20 AR/R pairs with random per-ID shuffle → in-order output, occupancy returns to 0. Then R ID7 with nothing pending → err_unexpected_o=1, no output beat.
- Mid-operation reset: 3 pending, assert rst 1 cycle → all outputs at reset values, occupancy_o=0.

Source files
------------

// File: rtl/axi_read_reorder_buffer_pkg.sv
// rob_pkg: shared types for the read reorder buffer.
package rob_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;
endpackage

// File: rtl/axi_read_reorder_buffer_oldest_match.sv
// rob_oldest_match: finds the first set candidate bit searching circularly from head.
module rob_oldest_match #(
  parameter int DEPTH = 8
) (
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [DEPTH-1:0]         cand_i,
  output logic                     found_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);
  localparam int W = $clog2(DEPTH);
  always_comb begin
    found_o = |cand_i;
    idx_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (cand_i[head_i + W'(i)]) idx_o = head_i + W'(i);
  end
endmodule

// File: rtl/axi_read_reorder_buffer.sv
// axi_read_reorder_buffer: returns single-beat read responses in AR issue order.
module axi_read_reorder_buffer
  import rob_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_WIDTH-1:0]      s_arid_i,
  input  logic                     s_arvalid_i,
  output logic                     s_arready_o,
  output logic [DATA_WIDTH-1:0]    s_rdata_o,
  output logic [1:0]               s_rresp_o,
  output logic [ID_WIDTH-1:0]      s_rid_o,
  output logic                     s_rvalid_o,
  input  logic                     s_rready_i,
  output logic [ID_WIDTH-1:0]      m_arid_o,
  output logic                     m_arvalid_o,
  input  logic                     m_arready_i,
  input  logic [DATA_WIDTH-1:0]    m_rdata_i,
  input  logic [1:0]               m_rresp_i,
  input  logic [ID_WIDTH-1:0]      m_rid_i,
  input  logic                     m_rvalid_i,
  output logic                     m_rready_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     err_unexpected_o
);
  localparam int W = $clog2(DEPTH);
  typedef struct packed {
    logic                  alloc;
    logic                  filled;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    resp_t                 resp;
  } slot_t;
  slot_t slot_q [DEPTH];
  slot_t slot_d [DEPTH];
  logic [W-1:0] head_q, head_d, tail_q, tail_d, match_idx;
  logic [W:0] count_q, count_d;
  logic err_q, err_d, full, push, pop, rx, found;
  logic [DEPTH-1:0] cand;
  assign full = count_q == (W+1)'(DEPTH);
  assign s_arready_o = m_arready_i && !full && !rst;
  assign m_arvalid_o = s_arvalid_i && !full && !rst;
  assign m_arid_o = s_arid_i;
  assign m_rready_o = !rst;
  assign s_rvalid_o = slot_q[head_q].alloc && slot_q[head_q].filled;
  assign s_rdata_o = slot_q[head_q].data;
  assign s_rresp_o = slot_q[head_q].resp;
  assign s_rid_o = slot_q[head_q].id;
  assign occupancy_o = count_q;
  assign err_unexpected_o = err_q;
  assign push = s_arvalid_i && s_arready_o;
  assign pop = s_rvalid_o && s_rready_i;
  assign rx = m_rvalid_i && m_rready_o;
  always_comb
    for (int i = 0; i < DEPTH; i++)
      cand[i] = slot_q[i].alloc && !slot_q[i].filled && slot_q[i].id == m_rid_i;
  rob_oldest_match #(.DEPTH(DEPTH)) u_match (
    .head_i (head_q),
    .cand_i (cand),
    .found_o(found),
    .idx_o  (match_idx)
  );
  // Match uses pre-edge slot state, so a slot allocated this cycle cannot be hit.
  always_comb begin
    slot_d = slot_q;
    if (rx && found) begin
      slot_d[match_idx].filled = 1'b1;
      slot_d[match_idx].data = m_rdata_i;
      slot_d[match_idx].resp = resp_t'(m_rresp_i);
    end
    if (pop) slot_d[head_q] = '0;
    if (push) slot_d[tail_q] = '{alloc: 1'b1, filled: 1'b0, id: s_arid_i, data: '0, resp: OKAY};
    head_d = head_q + W'(pop);
    tail_d = tail_q + W'(push);
    count_d = count_q + (W+1)'(push) - (W+1)'(pop);
    err_d = err_q || (rx && !found);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      err_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_axi_read_reorder_buffer.sv
// tb_axi_read_reorder_buffer: randomized and directed checks against an issue-order queue model.
module tb_axi_read_reorder_buffer;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1;
  logic [IW-1:0] s_arid_i = 0, m_arid_o, m_rid_i = 0, s_rid_o;
  logic s_arvalid_i = 0, s_arready_o, s_rvalid_o, s_rready_i = 1;
  logic [DW-1:0] s_rdata_o, m_rdata_i = 0;
  logic [1:0] s_rresp_o, m_rresp_i = 0;
  logic m_arvalid_o, m_arready_i = 1, m_rvalid_i = 0, m_rready_o, err_unexpected_o;
  logic [$clog2(DEPTH):0] occupancy_o;
  int n_chk = 0, n_pass = 0, issued;

  typedef struct {int id; bit fill; int data; int resp;} ent_t;
  ent_t mq[$];
  ent_t popped[$];
  bit merr = 0;

  always #5 clk = ~clk;

  axi_read_reorder_buffer #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_arid_i(s_arid_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rid_o(s_rid_o),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .m_arid_o(m_arid_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rid_i(m_rid_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .occupancy_o(occupancy_o), .err_unexpected_o(err_unexpected_o)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock cycle: drive at negedge, compare against model, advance model, return at next negedge idle.
  task automatic step(input bit av, input int aid, input bit rv, input int rid,
                      input int rd, input int rr, input bit sr, input bit mar);
    bit full, ev;
    int j;
    s_arvalid_i = av; s_arid_i = IW'(aid); m_rvalid_i = rv; m_rid_i = IW'(rid);
    m_rdata_i = DW'(rd); m_rresp_i = 2'(rr); s_rready_i = sr; m_arready_i = mar;
    #1;
    full = mq.size() == DEPTH;
    ev = mq.size() > 0 && mq[0].fill;
    chk("occ", occupancy_o, mq.size());
    chk("s_rvalid", s_rvalid_o, ev);
    if (ev) begin
      chk("s_rdata", s_rdata_o, mq[0].data);
      chk("s_rresp", s_rresp_o, mq[0].resp);
      chk("s_rid", s_rid_o, mq[0].id);
    end
    chk("s_arready", s_arready_o, mar && !full);
    chk("m_arvalid", m_arvalid_o, av && !full);
    chk("m_arid", m_arid_o, aid);
    chk("m_rready", m_rready_o, 1);
    chk("err", err_unexpected_o, merr);
    if (rv) begin
      j = -1;
      for (int k = 0; k < mq.size(); k++)
        if (j < 0 && !mq[k].fill && mq[k].id == rid) j = k;
      if (j < 0) merr = 1;
      else begin mq[j].fill = 1; mq[j].data = rd; mq[j].resp = rr; end
    end
    if (ev && sr) begin popped.push_back(mq[0]); void'(mq.pop_front()); end
    if (av && mar && !full) mq.push_back('{id: aid, fill: 0, data: 0, resp: 0});
    @(posedge clk);
    @(negedge clk);
    s_arvalid_i = 0; m_rvalid_i = 0; s_rready_i = 1; m_arready_i = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  task automatic drain();
    int un[$];
    for (int c = 0; c < 100 && mq.size() > 0; c++) begin
      un.delete();
      foreach (mq[k]) if (!mq[k].fill) un.push_back(mq[k].id);
      if (un.size() > 0)
        step(0, 0, 1, un[$urandom_range(0, un.size() - 1)], $urandom_range(0, 255), $urandom_range(0, 3), 1, 1);
      else idle(1);
    end
    chk("drain_occ", occupancy_o, 0);
  endtask

  task automatic do_reset();
    rst = 1; s_arvalid_i = 1; m_rvalid_i = 0;
    #1;
    chk("rst_m_arvalid", m_arvalid_o, 0);
    chk("rst_s_arready", s_arready_o, 0);
    chk("rst_m_rready", m_rready_o, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_occ", occupancy_o, 0);
    chk("rst_s_rvalid", s_rvalid_o, 0);
    chk("rst_s_rdata", s_rdata_o, 0);
    chk("rst_s_rresp", s_rresp_o, 0);
    chk("rst_s_rid", s_rid_o, 0);
    chk("rst_err", err_unexpected_o, 0);
    rst = 0; s_arvalid_i = 0;
    mq.delete(); merr = 0;
  endtask

  initial begin
    int un[$];
    bit av, rv, mar;
    int rid;
    @(negedge clk);
    do_reset();
    // Basic reorder
    popped.delete();
    step(1, 1, 0, 0, 0, 0, 1, 1);
    step(1, 2, 0, 0, 0, 0, 1, 1);
    step(1, 3, 0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 3, 'h33, 0, 1, 1);
    step(0, 0, 1, 1, 'h11, 0, 1, 1);
    step(0, 0, 1, 2, 'h22, 0, 1, 1);
    idle(3);
    chk("basic_cnt", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("basic0", popped[0].data, 'h11);
      chk("basic1", popped[1].data, 'h22);
      chk("basic2", popped[2].data, 'h33);
      chk("basic_id2", popped[2].id, 3);
    end
    // Same ID outstanding, then cross-ID hold
    popped.delete();
    step(1, 5, 0, 0, 0, 0, 1, 1);
    step(1, 5, 0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 5, 'hA0, 0, 1, 1);
    step(0, 0, 1, 5, 'hB0, 0, 1, 1);
    idle(2);
    step(1, 5, 0, 0, 0, 0, 1, 1);
    step(1, 6, 0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 6, 'h66, 0, 1, 1);
    idle(2);
    chk("held_rvalid", s_rvalid_o, 0);
    step(0, 0, 1, 5, 'h55, 1, 1, 1);
    idle(3);
    chk("same_cnt", popped.size(), 4);
    if (popped.size() == 4) begin
      chk("same0", popped[0].data, 'hA0);
      chk("same1", popped[1].data, 'hB0);
      chk("hold0", popped[2].data, 'h55);
      chk("hold1", popped[3].data, 'h66);
    end
    // Full and backpressure
    for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0, 0, 0, 1, 1);
    step(1, 8, 0, 0, 0, 0, 1, 1);
    chk("full_occ", occupancy_o, DEPTH);
    chk("full_arready", s_arready_o, 0);
    step(1, 8, 1, 0, 'h40, 0, 1, 1);
    step(1, 8, 0, 0, 0, 0, 1, 1);
    chk("unfull_arready", s_arready_o, 1);
    step(1, 8, 0, 0, 0, 0, 1, 1);
    drain();
    // Upstream stall
    step(1, 9, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 9, 'h5A, 2, 0, 1);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 1);
    s_rready_i = 0;
    #1;
    chk("stall_data", s_rdata_o, 'h5A);
    chk("stall_resp", s_rresp_o, 2);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("stall_pop_occ", occupancy_o, 0);
    // Randomized traffic with wrap
    issued = 0;
    for (int c = 0; c < 600 && (issued < 20 || mq.size() > 0); c++) begin
      un.delete();
      foreach (mq[k]) if (!mq[k].fill) un.push_back(mq[k].id);
      av = issued < 20 && $urandom_range(0, 1) == 1;
      mar = $urandom_range(0, 3) != 0;
      if (av && mar && mq.size() < DEPTH) issued++;
      rv = un.size() > 0 && $urandom_range(0, 1) == 1;
      rid = rv ? un[$urandom_range(0, un.size() - 1)] : 0;
      step(av, $urandom_range(0, 3), rv, rid, $urandom_range(0, 255), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, mar);
    end
    chk("rnd_issued", issued, 20);
    chk("rnd_occ", occupancy_o, 0);
    // Unexpected response
    step(0, 0, 1, 7, 'h77, 0, 1, 1);
    chk("unexp_err", err_unexpected_o, 1);
    chk("unexp_rvalid", s_rvalid_o, 0);
    idle(1);
    // Mid-operation reset, then a late beat
    step(1, 1, 0, 0, 0, 0, 1, 1);
    step(1, 2, 0, 0, 0, 0, 1, 1);
    step(1, 3, 0, 0, 0, 0, 1, 1);
    do_reset();
    step(0, 0, 1, 1, 'h99, 0, 1, 1);
    chk("late_err", err_unexpected_o, 1);
    chk("late_occ", occupancy_o, 0);
    idle(1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
